// File: rtl/aes128_ctrl_pkg.sv
// Shared types and constants for the AES-128 PRNG-fed encryption controller.
package aes128_ctrl_pkg;

    localparam int SEED_W            = 80;
    localparam int RESEED_PERIOD_DEF = 1024;
    localparam int CNT_W_DEF         = 16;

    typedef enum logic [2:0] {
        ST_NEED_SEED,
        ST_RESEED_START,
        ST_RESEED_WAIT,
        ST_IDLE,
        ST_RUN,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/aes128_prng_ctrl_if.sv
// Host, AES-core and PRNG control signals of the controller, bundled as one interface.
interface aes128_prng_ctrl_if
    import aes128_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic [SEED_W-1:0] host_seed;
    logic              host_seed_valid;
    logic              host_seed_ready;
    logic              host_valid;
    logic              host_ready;
    logic              host_cipher_valid;
    logic              host_cipher_ready;
    logic              aes_valid_in;
    logic              aes_ready;
    logic              aes_cipher_valid;
    logic [SEED_W-1:0] prng_seed;
    logic              prng_start_reseed;
    logic              prng_busy;
    logic              prng_out_valid;
    logic              prng_out_ready;
    logic [CNT_W-1:0]  enc_count;
    logic              need_reseed;
    logic              rnd_err;

    // Controller side.
    modport master (
        input  host_seed, host_seed_valid, host_valid, host_cipher_ready,
               aes_ready, aes_cipher_valid, prng_busy, prng_out_valid,
        output host_seed_ready, host_ready, host_cipher_valid, aes_valid_in,
               prng_seed, prng_start_reseed, prng_out_ready,
               enc_count, need_reseed, rnd_err
    );

    // Host, AES core and PRNG side.
    modport slave (
        output host_seed, host_seed_valid, host_valid, host_cipher_ready,
               aes_ready, aes_cipher_valid, prng_busy, prng_out_valid,
        input  host_seed_ready, host_ready, host_cipher_valid, aes_valid_in,
               prng_seed, prng_start_reseed, prng_out_ready,
               enc_count, need_reseed, rnd_err
    );
endinterface

// File: rtl/aes128_enc_counter.sv
// Saturating count of encryptions since the last reseed, with clear and threshold compare.
module aes128_enc_counter #(
    parameter int CNT_W  = 16,
    parameter int THRESH = 1024
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             at_thresh_o
);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        // NOTE: every combinationally written signal gets a default first so no latch is inferred.
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all flops update together.
        if (!nrst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign at_thresh_o = (count_q >= THRESH_C);

endmodule

// File: rtl/aes128_prng_ctrl.sv
// Sequences PRNG reseeds and AES-128 encryptions, enforcing a reseed every RESEED_PERIOD uses.
module aes128_prng_ctrl
    import aes128_ctrl_pkg::*;
#(
    parameter int RESEED_PERIOD = RESEED_PERIOD_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               nrst,
    aes128_prng_ctrl_if.master bus
);
    state_e            state_q, state_d;
    logic [SEED_W-1:0] seed_q, seed_d;
    logic              rnd_err_q, rnd_err_d;
    logic              start_q;
    logic              cvalid_q;

    logic              cnt_clr;
    logic              cnt_inc;
    logic              at_thresh;
    logic [CNT_W-1:0]  enc_count;

    logic              need_reseed;
    logic              host_ready;
    logic              accept;
    logic              seed_ready;
    logic              rnd_ready;

    aes128_enc_counter #(
        .CNT_W  (CNT_W),
        .THRESH (RESEED_PERIOD)
    ) u_enc_counter (
        .clk         (clk),
        .nrst        (nrst),
        .clr_i       (cnt_clr),
        .inc_i       (cnt_inc),
        .count_o     (enc_count),
        .at_thresh_o (at_thresh)
    );

    // State register; the pulse outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= ST_NEED_SEED;
            seed_q    <= '0;
            rnd_err_q <= 1'b0;
            start_q   <= 1'b0;
            cvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            seed_q    <= seed_d;
            rnd_err_q <= rnd_err_d;
            start_q   <= (state_d == ST_RESEED_START);
            cvalid_q  <= (state_d == ST_HOLD);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        seed_d    = seed_q;
        rnd_err_d = rnd_err_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state_q)
            ST_NEED_SEED: begin
                if (bus.host_seed_valid) begin
                    seed_d  = bus.host_seed;
                    state_d = ST_RESEED_START;
                end
            end
            ST_RESEED_START: state_d = ST_RESEED_WAIT;
            ST_RESEED_WAIT: begin
                if (!bus.prng_busy) begin
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // A pending seed takes priority over an encryption request.
                if (bus.host_seed_valid) begin
                    seed_d  = bus.host_seed;
                    state_d = ST_RESEED_START;
                end else if (accept) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.prng_out_valid) begin
                    rnd_err_d = 1'b1;
                end
                if (bus.aes_cipher_valid) begin
                    cnt_inc = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.host_cipher_ready) begin
                    state_d = at_thresh ? ST_NEED_SEED : ST_IDLE;
                end
            end
            default: state_d = ST_NEED_SEED;
        endcase
    end

    // Combinational outputs, forced to their idle values while reset is held.
    always_comb begin
        need_reseed = at_thresh || (state_q == ST_NEED_SEED);
        host_ready  = nrst && (state_q == ST_IDLE) && bus.aes_ready
                      && bus.prng_out_valid && !need_reseed;
        accept      = host_ready && bus.host_valid && !bus.host_seed_valid;
        seed_ready  = !nrst || (state_q == ST_NEED_SEED) || (state_q == ST_IDLE);
        rnd_ready   = accept || (nrst && (state_q == ST_RUN));
    end

    assign bus.host_ready        = host_ready;
    assign bus.host_seed_ready   = seed_ready;
    assign bus.aes_valid_in      = accept;
    assign bus.prng_out_ready    = rnd_ready;
    assign bus.need_reseed       = need_reseed;
    assign bus.prng_seed         = seed_q;
    assign bus.prng_start_reseed = start_q;
    assign bus.host_cipher_valid = cvalid_q;
    assign bus.enc_count         = enc_count;
    assign bus.rnd_err           = rnd_err_q;

endmodule
